fmul_issue_arbiter: RTL and testbench

Shares one pipelined `wallace_mul` FMUL datapath between NREQ VLIW issue slots. It picks one request per cycle in round-robin order and registers the operands into the multiplier. A tag/sign shadow pipeline tracks each operation alongside the multiplier, so every result is steered into its owner slot's response queue. A per-slot credit scheme guarantees a queue can never overflow, because the multiplier pipeline has no stall.

---
 rtl/fmul_ctrl_pkg.sv | 15 +
 rtl/fmul_rsp_fifo.sv | 43 ++++
 rtl/fmul_issue_arbiter.sv | 123 ++++++++++++
 tb/tb_fmul_issue_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_ctrl_pkg.sv
// fmul_ctrl_pkg: IEEE-754 single-precision field layout shared by the FMUL issue logic
package fmul_ctrl_pkg;
  localparam int FP_W = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam int MAN_HI = 22;
  localparam int MAN_LO = 0;
  function automatic logic [FP_W-1:0] fp_pack(input logic sign, input logic [EXP_W-1:0] exp_f,
                                             input logic [MAN_W-1:0] man_f);
    return {sign, exp_f, man_f};
  endfunction
endpackage

// File: rtl/fmul_rsp_fifo.sv
// fmul_rsp_fifo: circular response FIFO; head reads as zero while empty
module fmul_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && valid;
  assign do_push = push && !full;
  assign head = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? nxt(wr_ptr) : wr_ptr;
      rd_ptr <= do_pop ? nxt(rd_ptr) : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fmul_issue_arbiter.sv
// fmul_issue_arbiter: round-robin issue of NREQ slots into one pipelined FMUL,
// with a tag/sign shadow pipe steering results into credit-protected per-slot queues
module fmul_issue_arbiter
  import fmul_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT = 2,
  parameter int TAG_W = 5,
  parameter int RQ_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*FP_W-1:0]  req_a,
  input  logic [NREQ*FP_W-1:0]  req_b,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output logic [EXP_W-1:0]      mul_exp_1,
  output logic [EXP_W-1:0]      mul_exp_2,
  output logic [MAN_W-1:0]      mul_man_1,
  output logic [MAN_W-1:0]      mul_man_2,
  input  logic [EXP_W-1:0]      mul_final_exp,
  input  logic [MAN_W-1:0]      mul_final_man,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [NREQ*FP_W-1:0]  rsp_data,
  output logic [NREQ*TAG_W-1:0] rsp_tag,
  output logic                  busy
);
  localparam int SLOT_W = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(RQ_DEPTH + 1);
  localparam int QW = TAG_W + FP_W;
  typedef struct packed {
    logic              valid;
    logic [SLOT_W-1:0] slot;
    logic [TAG_W-1:0]  tag;
    logic              sign;
  } shadow_t;
  logic [SLOT_W-1:0] ptr, grant_idx;
  logic grant_any;
  int k;
  logic [NREQ-1:0] eligible, push, pop, q_full;
  logic [CNT_W-1:0] credit [NREQ];
  logic [FP_W-1:0] a_arr [NREQ];
  logic [FP_W-1:0] b_arr [NREQ];
  logic [TAG_W-1:0] tag_arr [NREQ];
  logic [QW-1:0] head [NREQ];
  logic [FP_W-1:0] a_sel, b_sel;
  logic [QW-1:0] wb_data;
  shadow_t sh [LAT+1];
  // Scan from the highest offset down so the first eligible slot at/after ptr wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    k = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      k = k >= NREQ ? k - NREQ : k;
      if (eligible[k[SLOT_W-1:0]]) begin
        grant_any = rst_n;
        grant_idx = k[SLOT_W-1:0];
      end
    end
    req_ready = '0;
    req_ready[grant_idx] = grant_any;
  end
  assign a_sel = a_arr[grant_idx];
  assign b_sel = b_arr[grant_idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      mul_exp_1 <= '0;
      mul_exp_2 <= '0;
      mul_man_1 <= '0;
      mul_man_2 <= '0;
    end else if (grant_any) begin
      ptr <= grant_idx == SLOT_W'(NREQ - 1) ? '0 : grant_idx + 1'b1;
      mul_exp_1 <= a_sel[EXP_HI:EXP_LO];
      mul_exp_2 <= b_sel[EXP_HI:EXP_LO];
      mul_man_1 <= a_sel[MAN_HI:MAN_LO];
      mul_man_2 <= b_sel[MAN_HI:MAN_LO];
    end
  end
  // Stage 0 loads alongside the operand register; stage LAT lines up with the FMUL result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LAT; i++) sh[i] <= '0;
      for (int s = 0; s < NREQ; s++) credit[s] <= CNT_W'(RQ_DEPTH);
    end else begin
      sh[0] <= '{valid: grant_any, slot: grant_idx, tag: tag_arr[grant_idx],
                 sign: a_sel[SIGN_BIT] ^ b_sel[SIGN_BIT]};
      for (int i = 1; i <= LAT; i++) sh[i] <= sh[i-1];
      for (int s = 0; s < NREQ; s++)
        if (req_ready[s] != pop[s]) credit[s] <= req_ready[s] ? credit[s] - 1'b1 : credit[s] + 1'b1;
    end
  end
  assign wb_data = {sh[LAT].tag, fp_pack(sh[LAT].sign, mul_final_exp, mul_final_man)};
  for (genvar s = 0; s < NREQ; s++) begin : g_slot
    assign a_arr[s] = req_a[s*FP_W +: FP_W];
    assign b_arr[s] = req_b[s*FP_W +: FP_W];
    assign tag_arr[s] = req_tag[s*TAG_W +: TAG_W];
    assign eligible[s] = req_valid[s] && credit[s] != '0;
    assign push[s] = sh[LAT].valid && sh[LAT].slot == SLOT_W'(s);
    assign pop[s] = rsp_valid[s] && rsp_ready[s];
    fmul_rsp_fifo #(.WIDTH(QW), .DEPTH(RQ_DEPTH)) u_q (
      .clk(clk),
      .rst_n(rst_n),
      .push(push[s]),
      .push_data(wb_data),
      .pop(pop[s]),
      .valid(rsp_valid[s]),
      .full(q_full[s]),
      .head(head[s])
    );
    assign rsp_data[s*FP_W +: FP_W] = head[s][FP_W-1:0];
    assign rsp_tag[s*TAG_W +: TAG_W] = head[s][QW-1:FP_W];
    always @(posedge clk) if (rst_n && push[s]) assert (!q_full[s]);
  end
  always_comb begin
    busy = |rsp_valid;
    for (int i = 0; i <= LAT; i++) busy = busy | sh[i].valid;
  end
endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// tb_fmul_issue_arbiter: arbiter bench with a 2-stage FMUL model and per-slot scoreboard queues
module tb_fmul_issue_arbiter;
  localparam int NREQ = 2;
  localparam int LAT = 2;
  localparam int TAG_W = 5;
  localparam int RQ_DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] rsp_ready = 2'b11;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [9:0] req_tag = '0;
  logic [1:0] req_ready, rsp_valid;
  logic [7:0] mul_exp_1, mul_exp_2, mul_final_exp;
  logic [22:0] mul_man_1, mul_man_2, mul_final_man;
  logic [63:0] rsp_data;
  logic [9:0] rsp_tag;
  logic busy;
  logic [30:0] st1, st2;
  logic [36:0] q0[$];
  logic [36:0] q1[$];
  logic [36:0] mon_got, mon_want;
  int vectors = 0;
  int errors = 0;
  int pops [2] = '{0, 0};

  fmul_issue_arbiter #(.NREQ(NREQ), .LAT(LAT), .TAG_W(TAG_W), .RQ_DEPTH(RQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .mul_exp_1(mul_exp_1), .mul_exp_2(mul_exp_2), .mul_man_1(mul_man_1), .mul_man_2(mul_man_2),
    .mul_final_exp(mul_final_exp), .mul_final_man(mul_final_man),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Magnitude-only multiply of normal operands, truncated; the sign travels in the DUT
  function automatic logic [30:0] fmul_mag(input logic [7:0] e1, input logic [22:0] m1,
                                           input logic [7:0] e2, input logic [22:0] m2);
    logic [47:0] p;
    logic [9:0] e;
    p = {1'b1, m1} * {1'b1, m2};
    e = {2'b0, e1} + {2'b0, e2} - 10'd127;
    return p[47] ? {e[7:0] + 8'd1, p[46:24]} : {e[7:0], p[45:23]};
  endfunction

  always @(posedge clk) begin
    st1 <= fmul_mag(mul_exp_1, mul_man_1, mul_exp_2, mul_man_2);
    st2 <= st1;
  end
  assign mul_final_exp = st2[30:23];
  assign mul_final_man = st2[22:0];

  function automatic logic [36:0] expect_of(input int s);
    logic [31:0] a, b;
    a = req_a[32*s +: 32];
    b = req_b[32*s +: 32];
    return {req_tag[5*s +: 5], a[31] ^ b[31], fmul_mag(a[30:23], a[22:0], b[30:23], b[22:0])};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (req_ready[0]) q0.push_back(expect_of(0));
      if (req_ready[1]) q1.push_back(expect_of(1));
      for (int s = 0; s < 2; s++) begin
        if (rsp_valid[s] && rsp_ready[s]) begin
          mon_got = {rsp_tag[5*s +: 5], rsp_data[32*s +: 32]};
          vectors++;
          if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL sb_unexpected slot%0d got %h required none", s, mon_got);
          end else begin
            if (s == 0) mon_want = q0.pop_front();
            else mon_want = q1.pop_front();
            if (mon_got !== mon_want) begin
              errors++;
              $display("FAIL sb_data slot%0d got %h required %h", s, mon_got, mon_want);
            end
          end
          pops[s]++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy got %b required 0", busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_a = {32'h40000000, 32'h3F800000};
    req_b = {32'h40000000, 32'h3F800000};
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_ready got %b required 00", req_ready);
    end
    vectors++;
    if ({rsp_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valid_busy got %b required 000", {rsp_valid, busy});
    end
    vectors++;
    if ({mul_exp_1, mul_exp_2, mul_man_1, mul_man_2} !== 62'd0) begin
      errors++;
      $display("FAIL reset_mul got %h required 0", {mul_exp_1, mul_exp_2, mul_man_1, mul_man_2});
    end
    vectors++;
    if ({rsp_data, rsp_tag} !== 74'd0) begin
      errors++;
      $display("FAIL reset_rsp got %h required 0", {rsp_data, rsp_tag});
    end
    req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_op(input logic [1:0] vmask);
    @(posedge clk);
    #1;
    req_valid = vmask;
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'h40400000;
    req_tag[4:0] = 5'd3;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_grant got %b required 01", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    vectors++;
    if ({mul_exp_1, mul_man_1, mul_exp_2, mul_man_2} !== {8'h80, 23'h0, 8'h80, 23'h400000}) begin
      errors++;
      $display("FAIL single_mul_ops got %h required %h", {mul_exp_1, mul_man_1, mul_exp_2, mul_man_2},
               {8'h80, 23'h0, 8'h80, 23'h400000});
    end
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (rsp_valid[0] !== (e == 3)) begin
        errors++;
        $display("FAIL single_latency edge+%0d rsp_valid got %b required %b", e, rsp_valid[0], e == 3);
      end
    end
    vectors++;
    if ({rsp_tag[4:0], rsp_data[31:0]} !== {5'd3, 32'h40C00000}) begin
      errors++;
      $display("FAIL single_result got %h/%h required 3/40c00000", rsp_tag[4:0], rsp_data[31:0]);
    end
    vectors++;
    if (mul_exp_1 !== 8'h80 || mul_man_2 !== 23'h400000) begin
      errors++;
      $display("FAIL mul_hold got %h/%h required 80/400000", mul_exp_1, mul_man_2);
    end
    wait_idle();
  endtask

  task automatic test_sign;
    int n;
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    req_a[63:32] = 32'hBFC00000;
    req_b[63:32] = 32'h40000000;
    req_tag[9:5] = 5'd7;
    @(posedge clk);
    #1 req_valid = 2'b00;
    n = 0;
    while (!rsp_valid[1] && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n !== 3) begin
      errors++;
      $display("FAIL sign_latency got %0d required 3", n);
    end
    vectors++;
    if ({rsp_tag[9:5], rsp_data[63:32]} !== {5'd7, 32'hC0400000}) begin
      errors++;
      $display("FAIL sign_result got %h/%h required 7/c0400000", rsp_tag[9:5], rsp_data[63:32]);
    end
    wait_idle();
  endtask

  task automatic test_round_robin;
    logic [31:0] ops [8];
    int p0, p1;
    ops = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000,
            32'h3F000000, 32'hC0200000, 32'h3FA00000, 32'hC0800000};
    p0 = pops[0];
    p1 = pops[1];
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      req_valid = 2'b11;
      req_a = {ops[(c+1)%8], ops[c]};
      req_b = {ops[(c+3)%8], ops[(c+5)%8]};
      req_tag = {5'(c + 10), 5'(c)};
      @(negedge clk);
      vectors++;
      if (req_ready !== (c % 2 == 0 ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL rr_grant cycle%0d got %b required %b", c, req_ready, c % 2 == 0 ? 2'b01 : 2'b10);
      end
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_idle();
    vectors++;
    if (pops[0] - p0 !== 3 || pops[1] - p1 !== 3) begin
      errors++;
      $display("FAIL rr_counts got %0d/%0d required 3/3", pops[0] - p0, pops[1] - p1);
    end
  endtask

  task automatic test_backpressure;
    int g0, g1;
    logic [1:0] last_ready;
    g0 = 0;
    g1 = 0;
    @(posedge clk);
    #1;
    rsp_ready = 2'b10;
    req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      req_a = {32'h3FC00000 ^ 32'(c << 20), 32'h40000000 ^ 32'(c << 19)};
      req_b = {32'h40400000, 32'hBF800000 ^ 32'(c << 21)};
      req_tag = {5'(c + 16), 5'(c)};
      @(negedge clk);
      g0 += int'(req_ready[0]);
      g1 += int'(req_ready[1]);
      last_ready = req_ready;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (g0 !== RQ_DEPTH) begin
      errors++;
      $display("FAIL bp_slot0_grants got %0d required %0d", g0, RQ_DEPTH);
    end
    vectors++;
    if (g1 < 6 || last_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_slot1_progress got %0d grants last_ready %b required >=6 and slot0 idle", g1, last_ready);
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL pop_no_grant got %b required 10", req_ready);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b10;
    g0 = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        vectors++;
        if (req_ready !== 2'b01) begin
          errors++;
          $display("FAIL regrant got %b required 01", req_ready);
        end
      end
      g0 += int'(req_ready[0]);
      @(posedge clk);
      #1;
    end
    vectors++;
    if (g0 !== 1) begin
      errors++;
      $display("FAIL one_credit_grants got %0d required 1", g0);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_idle();
  endtask

  task automatic test_reset_mid;
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    req_a = {32'h40400000, 32'h3FC00000};
    req_b = {32'h40000000, 32'h40000000};
    req_tag = {5'd21, 5'd12};
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b00;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midflight_busy got %b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rsp_valid, busy, req_ready} !== 5'b0 || {rsp_data, rsp_tag} !== 74'd0 ||
        {mul_exp_1, mul_exp_2, mul_man_1, mul_man_2} !== 62'd0) begin
      errors++;
      $display("FAIL async_reset got valid %b busy %b mul %h required all 0", rsp_valid, busy,
               {mul_exp_1, mul_exp_2, mul_man_1, mul_man_2});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL late_response cycle%0d rsp_valid %b busy %b required 00/0", c, rsp_valid, busy);
      end
    end
    test_single_op(2'b11);
  endtask

  initial begin
    test_reset();
    test_single_op(2'b01);
    test_sign();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d/%0d required 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
